// File: rtl/edid_pkg.sv
// Shared types and constants for the EDID DDC slave: FSM states, CTRL register map
// and the default device address.
package edid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEV,
      ST_DEV_ACK,
      ST_WORD,
      ST_WORD_ACK,
      ST_TX,
      ST_TX_ACKCHK,
      ST_IGNORE
   } edid_state_e;

   localparam logic [8:0] CTRL_ADDR      = 9'h100;
   localparam int         CTRL_EN_BIT    = 0;
   localparam int         CTRL_BUSY_BIT  = 1;
   localparam int         CTRL_RDONE_BIT = 2;
   localparam int         CTRL_PTR_LSB   = 8;
   localparam int         CTRL_PTR_MSB   = 15;
   localparam logic [6:0] DEF_DEV_ADDR   = 7'h50;

endpackage

// File: rtl/edid_i2c_slave_if.sv
// Avalon-MM register port plus the DDC pin signals of the EDID slave.
interface edid_i2c_slave_if;
   logic [8:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        scl_in;
   logic        sda_in;
   logic        sda_oe;

   modport slave  (input address, chipselect, write_n, writedata, scl_in, sda_in,
                   output readdata, sda_oe);
   modport master (output address, chipselect, write_n, writedata, scl_in, sda_in,
                   input readdata, sda_oe);
endinterface

// File: rtl/i2c_line_filter.sv
// Conditions one raw I2C line: 2-flop synchronizer, glitch filter, and one-cycle
// rise/fall pulses aligned with the filtered level change.
module i2c_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic line_in,
   output logic line_f,
   output logic rise,
   output logic fall
);
   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    sync_r;
   logic [CW-1:0] cnt_r;
   logic          filt_r;
   logic          rise_r;
   logic          fall_r;

   // Synchronize, then accept a new level only after FILTER_LEN equal samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= 2'b11;
         cnt_r  <= '0;
         filt_r <= 1'b1;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[0], line_in};
         rise_r <= 1'b0;
         fall_r <= 1'b0;
         if (sync_r[1] == filt_r) begin
            cnt_r <= '0;
         end else if (cnt_r == CW'(FILTER_LEN - 1)) begin
            cnt_r  <= '0;
            filt_r <= sync_r[1];
            rise_r <= sync_r[1];
            fall_r <= ~sync_r[1];
         end else begin
            cnt_r <= cnt_r + 1'b1;
         end
      end
   end

   assign line_f = filt_r;
   assign rise   = rise_r;
   assign fall   = fall_r;
endmodule

// File: rtl/edid_i2c_slave.sv
// EDID DDC slave: serves a 256-byte image over I2C; image and control are
// loaded through an Avalon-MM port.
module edid_i2c_slave
   import edid_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR   = DEF_DEV_ADDR,
   parameter int         FILTER_LEN = 3
) (
   input  logic            clk,
   input  logic            reset_n,
   edid_i2c_slave_if.slave bus
);
   logic        scl_f_s, scl_rise_s, scl_fall_s;
   logic        sda_f_s, sda_rise_s, sda_fall_s;
   logic        start_s, stop_s, wr_s, ctrl_wr_s, rd_set_s, unused_s;
   logic [7:0]  byte_in_s;
   logic [31:0] ctrl_s, rd_mux_s;

   edid_state_e state_r, state_nxt;
   logic [2:0]  bit_cnt_r, bit_cnt_nxt;
   logic [7:0]  shift_r, shift_nxt, pointer_r, pointer_nxt;
   logic        sda_oe_r, sda_oe_nxt, tx_any_r, tx_any_nxt;
   logic        word_done_r, word_done_nxt, load_pend_r, load_pend_nxt;
   logic        enable_r, read_done_r;
   logic [7:0]  ram_r [0:255];
   logic [7:0]  ram_q_r;
   logic [31:0] readdata_r;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
      .clk(clk), .reset_n(reset_n), .line_in(bus.scl_in),
      .line_f(scl_f_s), .rise(scl_rise_s), .fall(scl_fall_s));
   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
      .clk(clk), .reset_n(reset_n), .line_in(bus.sda_in),
      .line_f(sda_f_s), .rise(sda_rise_s), .fall(sda_fall_s));

   assign start_s   = sda_fall_s & scl_f_s;
   assign stop_s    = sda_rise_s & scl_f_s;
   assign byte_in_s = {shift_r[6:0], sda_f_s};
   assign wr_s      = bus.chipselect & ~bus.write_n;
   assign ctrl_wr_s = wr_s && (bus.address == CTRL_ADDR);
   assign unused_s  = ^bus.writedata[31:8];

   // Next-state and datapath decode; START/STOP override every state.
   always_comb begin
      state_nxt     = state_r;
      bit_cnt_nxt   = bit_cnt_r;
      shift_nxt     = shift_r;
      pointer_nxt   = pointer_r;
      sda_oe_nxt    = sda_oe_r;
      tx_any_nxt    = tx_any_r;
      word_done_nxt = word_done_r;
      load_pend_nxt = load_pend_r;
      rd_set_s      = 1'b0;
      if (start_s) begin
         state_nxt     = ST_DEV;
         bit_cnt_nxt   = 3'd0;
         sda_oe_nxt    = 1'b0;
         tx_any_nxt    = 1'b0;
         load_pend_nxt = 1'b0;
      end else if (stop_s) begin
         state_nxt     = ST_IDLE;
         sda_oe_nxt    = 1'b0;
         load_pend_nxt = 1'b0;
         rd_set_s      = tx_any_r;
      end else begin
         case (state_r)
            ST_DEV, ST_WORD: begin
               if (!scl_rise_s) begin
                  shift_nxt = shift_r;
               end else begin
                  shift_nxt   = byte_in_s;
                  bit_cnt_nxt = bit_cnt_r + 3'd1;
                  if (bit_cnt_r != 3'd7) begin
                     state_nxt = state_r;
                  end else if (state_r == ST_DEV) begin
                     state_nxt = ((byte_in_s[7:1] == DEV_ADDR) && enable_r) ? ST_DEV_ACK : ST_IGNORE;
                  end else if (!word_done_r) begin
                     pointer_nxt = byte_in_s;
                     state_nxt   = ST_WORD_ACK;
                  end else begin
                     state_nxt = ST_IGNORE;
                  end
               end
            end
            ST_DEV_ACK, ST_WORD_ACK: begin
               // sda_oe_r doubles as "ACK already driven" between the two SCL falls.
               if (!scl_fall_s) begin
                  sda_oe_nxt = sda_oe_r;
               end else if (!sda_oe_r) begin
                  sda_oe_nxt = 1'b1;
               end else begin
                  bit_cnt_nxt = 3'd0;
                  if ((state_r == ST_DEV_ACK) && shift_r[0]) begin
                     state_nxt  = ST_TX;
                     shift_nxt  = ram_q_r;
                     sda_oe_nxt = ~ram_q_r[7];
                  end else begin
                     state_nxt     = ST_WORD;
                     sda_oe_nxt    = 1'b0;
                     word_done_nxt = (state_r == ST_WORD_ACK);
                  end
               end
            end
            ST_TX: begin
               if (scl_rise_s) begin
                  bit_cnt_nxt = bit_cnt_r + 3'd1;
               end else if (!scl_fall_s) begin
                  bit_cnt_nxt = bit_cnt_r;
               end else if (load_pend_r) begin
                  shift_nxt     = ram_q_r;
                  sda_oe_nxt    = ~ram_q_r[7];
                  load_pend_nxt = 1'b0;
               end else if (bit_cnt_r == 3'd0) begin
                  sda_oe_nxt = 1'b0;
                  tx_any_nxt = 1'b1;
                  state_nxt  = ST_TX_ACKCHK;
               end else begin
                  sda_oe_nxt = ~shift_r[6];
                  shift_nxt  = {shift_r[6:0], 1'b0};
               end
            end
            ST_TX_ACKCHK: begin
               if (!scl_rise_s) begin
                  state_nxt = state_r;
               end else if (!sda_f_s) begin
                  pointer_nxt   = pointer_r + 8'd1;
                  bit_cnt_nxt   = 3'd0;
                  load_pend_nxt = 1'b1;
                  state_nxt     = ST_TX;
               end else begin
                  state_nxt = ST_IGNORE;
               end
            end
            ST_IDLE, ST_IGNORE: begin
               sda_oe_nxt = 1'b0;
            end
            default: begin
               state_nxt  = ST_IDLE;
               sda_oe_nxt = 1'b0;
            end
         endcase
      end
   end

   // FSM and I2C datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         bit_cnt_r   <= 3'd0;
         shift_r     <= 8'd0;
         pointer_r   <= 8'd0;
         sda_oe_r    <= 1'b0;
         tx_any_r    <= 1'b0;
         word_done_r <= 1'b0;
         load_pend_r <= 1'b0;
      end else begin
         state_r     <= state_nxt;
         bit_cnt_r   <= bit_cnt_nxt;
         shift_r     <= shift_nxt;
         pointer_r   <= pointer_nxt;
         sda_oe_r    <= sda_oe_nxt;
         tx_any_r    <= tx_any_nxt;
         word_done_r <= word_done_nxt;
         load_pend_r <= load_pend_nxt;
      end
   end

   // CTRL register: enable and sticky read_done (a new completion wins over a clear).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable_r    <= 1'b0;
         read_done_r <= 1'b0;
      end else begin
         enable_r <= ctrl_wr_s ? bus.writedata[CTRL_EN_BIT] : enable_r;
         if (rd_set_s) begin
            read_done_r <= 1'b1;
         end else if (ctrl_wr_s && bus.writedata[CTRL_RDONE_BIT]) begin
            read_done_r <= 1'b0;
         end else begin
            read_done_r <= read_done_r;
         end
      end
   end

   // EDID image: Avalon write port, registered read at the I2C pointer.
   always_ff @(posedge clk) begin
      if (wr_s && !bus.address[8]) begin
         ram_r[bus.address[7:0]] <= bus.writedata[7:0];
      end
      ram_q_r <= ram_r[pointer_r];
   end

   // Avalon read mux.
   always_comb begin
      ctrl_s                              = 32'd0;
      ctrl_s[CTRL_EN_BIT]                 = enable_r;
      ctrl_s[CTRL_BUSY_BIT]               = (state_r != ST_IDLE);
      ctrl_s[CTRL_RDONE_BIT]              = read_done_r;
      ctrl_s[CTRL_PTR_MSB:CTRL_PTR_LSB]   = pointer_r;
      if (!bus.address[8]) begin
         rd_mux_s = {24'd0, ram_r[bus.address[7:0]]};
      end else if (bus.address == CTRL_ADDR) begin
         rd_mux_s = ctrl_s;
      end else begin
         rd_mux_s = 32'd0;
      end
   end

   // Registered Avalon readdata.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_r <= 32'd0;
      end else begin
         readdata_r <= rd_mux_s;
      end
   end

   assign bus.readdata = readdata_r;
   assign bus.sda_oe   = sda_oe_r;
endmodule

// File: tb/tb_edid_i2c_slave.sv
// Bench for edid_i2c_slave: bit-banged I2C master on a wired-AND bus, checked
// against a byte-level model of the EDID image, pointer and CTRL word.
`timescale 1ns/1ps
module tb_edid_i2c_slave;
   localparam int H = 12;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic       scl_m   = 1'b1;
   logic       sda_m   = 1'b1;
   int         n_vec   = 0;
   int         n_err   = 0;
   int         oe_cnt  = 0;
   logic [7:0] ref_ram [256];
   logic [7:0] ref_ptr   = 8'd0;
   logic       ref_en    = 1'b0;
   logic       ref_rdone = 1'b0;

   edid_i2c_slave_if bus ();
   edid_i2c_slave #(.DEV_ADDR(7'h50), .FILTER_LEN(3)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus));

   assign bus.scl_in = scl_m;
   assign bus.sda_in = sda_m & ~bus.sda_oe;

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.sda_oe) oe_cnt <= oe_cnt + 1;

   initial begin
      #1500us;
      $display("FAIL watchdog: time limit reached got=running required=finished");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic av_write(input logic [8:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
   endtask

   task automatic av_read(input logic [8:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.address = a;
      @(negedge clk);
      d = bus.readdata;
   endtask

   task automatic ram_put(input logic [7:0] a, input logic [7:0] d);
      av_write({1'b0, a}, {24'd0, d});
      ref_ram[a] = d;
   endtask

   task automatic ctrl_put(input logic en, input logic clr);
      av_write(9'h100, {29'd0, clr, 1'b0, en});
      ref_en = en;
      if (clr) ref_rdone = 1'b0;
   endtask

   task automatic check_ctrl(input string tag, input logic busy);
      logic [31:0] d;
      av_read(9'h100, d);
      check_val(tag, d, {16'd0, ref_ptr, 5'd0, ref_rdone, busy, ref_en});
   endtask

   task automatic i2c_start();
      tick(H/2); sda_m = 1'b1; tick(H); scl_m = 1'b1; tick(H);
      sda_m = 1'b0; tick(H); scl_m = 1'b0; tick(H);
   endtask

   task automatic i2c_stop();
      tick(H/2); sda_m = 1'b0; tick(H); scl_m = 1'b1; tick(H); sda_m = 1'b1; tick(H);
   endtask

   task automatic bit_out(input logic b);
      tick(H/2); sda_m = b; tick(H/2); scl_m = 1'b1; tick(H); scl_m = 1'b0;
   endtask

   task automatic bit_in(output logic b);
      tick(H/2); sda_m = 1'b1; tick(H/2); scl_m = 1'b1; tick(H/2);
      b = bus.sda_in; tick(H/2); scl_m = 1'b0;
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) bit_out(d[i]);
      bit_in(b);
      ack = ~b;
   endtask

   task automatic rd_byte(input logic ack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         bit_in(b);
         d[i] = b;
      end
      bit_out(~ack);
   endtask

   // Optional offset write, repeated-start read of n bytes, STOP, then CTRL check.
   task automatic rd_txn(input string tag, input logic set_ofs, input logic [7:0] ofs,
                         input int n, input logic ack_last);
      logic       a;
      logic       ack;
      logic [7:0] d;
      if (set_ofs) begin
         i2c_start();
         wr_byte(8'hA0, a); check_val({tag, "_devw_ack"}, {31'd0, a}, 32'd1);
         wr_byte(ofs, a);   check_val({tag, "_ofs_ack"}, {31'd0, a}, 32'd1);
         ref_ptr = ofs;
      end
      i2c_start();
      wr_byte(8'hA1, a); check_val({tag, "_devr_ack"}, {31'd0, a}, 32'd1);
      for (int i = 0; i < n; i++) begin
         ack = (i < n - 1) || ack_last;
         rd_byte(ack, d);
         check_val({tag, "_data"}, {24'd0, d}, {24'd0, ref_ram[ref_ptr]});
         if (ack) ref_ptr = ref_ptr + 8'd1;
      end
      i2c_stop();
      if (n > 0) ref_rdone = 1'b1;
      check_ctrl({tag, "_ctrl"}, 1'b0);
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  rb;
      logic        a;
      int          oe0;
      int          x;
      int          n;
      bus.address = 9'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
      tick(3);
      @(negedge clk);
      check_val("rst_readdata", bus.readdata, 32'd0);
      check_val("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
      reset_n = 1'b1;
      tick(2);
      check_ctrl("rst_ctrl", 1'b0);

      for (int i = 0; i < 256; i++) ram_put(i[7:0], i[7:0] ^ 8'hA5);
      ctrl_put(1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         x = $urandom_range(0, 255);
         av_read(x[8:0], d);
         check_val("ram_rd", d, {24'd0, ref_ram[x]});
      end

      rd_txn("basic", 1'b1, 8'h10, 3, 1'b0);

      // Disabled: address NACKed, SDA never pulled, idle after STOP.
      ctrl_put(1'b0, 1'b1);
      oe0 = oe_cnt;
      i2c_start();
      wr_byte(8'hA1, a); check_val("dis_nack", {31'd0, a}, 32'd0);
      i2c_stop();
      check_val("dis_no_oe", oe_cnt - oe0, 32'd0);
      check_ctrl("dis_ctrl", 1'b0);

      // Wrong address, then a normal read after a fresh START.
      ctrl_put(1'b1, 1'b0);
      i2c_start();
      wr_byte(8'hA2, a); check_val("wrong_nack", {31'd0, a}, 32'd0);
      check_ctrl("wrong_ignore", 1'b1);
      rd_txn("after_wrong", 1'b0, 8'h00, 1, 1'b0);

      ram_put(8'h02, 8'hA7);
      rd_txn("wrap", 1'b1, 8'hFE, 4, 1'b1);

      // Write of a data byte is refused and leaves the image untouched.
      i2c_start();
      wr_byte(8'hA0, a); check_val("wr_dev_ack", {31'd0, a}, 32'd1);
      wr_byte(8'h20, a); check_val("wr_ofs_ack", {31'd0, a}, 32'd1);
      ref_ptr = 8'h20;
      wr_byte(8'h55, a); check_val("wr_data_nack", {31'd0, a}, 32'd0);
      i2c_stop();
      av_read(9'h020, d); check_val("wr_ram_kept", d, {24'd0, ref_ram[8'h20]});
      check_ctrl("wr_ctrl", 1'b0);

      for (int t = 0; t < 8; t++) begin
         for (int k = 0; k < 3; k++) ram_put(8'($urandom_range(0, 255)), 8'($urandom));
         if ($urandom_range(0, 1) == 1) ctrl_put(1'b1, 1'b1);
         n = $urandom_range(1, 4);
         rd_txn("rnd", ($urandom_range(0, 3) != 0), 8'($urandom), n, 1'b0);
      end

      // Glitches shorter than the filter must not be seen as START/STOP.
      @(negedge clk); sda_m = 1'b0; @(negedge clk); sda_m = 1'b1;
      tick(10);
      check_ctrl("glitch_idle", 1'b0);
      ctrl_put(1'b1, 1'b1);
      i2c_start();
      wr_byte(8'hA1, a); check_val("glitch_dev_ack", {31'd0, a}, 32'd1);
      rd_byte(1'b0, rb); check_val("glitch_data", {24'd0, rb}, {24'd0, ref_ram[ref_ptr]});
      tick(H/2); sda_m = 1'b0; tick(H/2); scl_m = 1'b1; tick(H);
      @(negedge clk); sda_m = 1'b1; @(negedge clk); sda_m = 1'b0;
      tick(10);
      check_ctrl("glitch_no_stop", 1'b1);
      sda_m = 1'b1; tick(H);
      ref_rdone = 1'b1;
      check_ctrl("glitch_real_stop", 1'b0);

      // Reset in the middle of a byte being transmitted.
      ram_put(8'h30, 8'h12);
      i2c_start();
      wr_byte(8'hA0, a); check_val("rst_devw_ack", {31'd0, a}, 32'd1);
      wr_byte(8'h30, a); check_val("rst_ofs_ack", {31'd0, a}, 32'd1);
      av_read(9'h030, d); check_val("rst_pre_rd", d, {24'd0, ref_ram[8'h30]});
      i2c_start();
      wr_byte(8'hA1, a); check_val("rst_devr_ack", {31'd0, a}, 32'd1);
      tick(10);
      @(negedge clk);
      check_val("tx_drive", {31'd0, bus.sda_oe}, {31'd0, ~ref_ram[8'h30][7]});
      #2 reset_n = 1'b0;
      #1;
      check_val("rst_async_oe", {31'd0, bus.sda_oe}, 32'd0);
      check_val("rst_async_rd", bus.readdata, 32'd0);
      scl_m = 1'b1; sda_m = 1'b1;
      tick(3);
      reset_n = 1'b1;
      ref_ptr = 8'd0; ref_en = 1'b0; ref_rdone = 1'b0;
      tick(2);
      check_ctrl("post_rst_ctrl", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
